// File: rtl/brew_sequencer.sv
// Recipe-code driven brew sequencer: walks heater, water, coffee and milk phases
// with a start/busy/done/err handshake toward the panel logic.
module brew_sequencer #(
    parameter int T_HEAT   = 8,
    parameter int T_WATER  = 6,
    parameter int T_COFFEE = 4,
    parameter int T_MILK   = 3,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1,
    input  logic       m0,
    input  logic       start,
    input  logic       cancel,
    output logic       heater,
    output logic       valve_agua,
    output logic       motor_cafe,
    output logic       valve_leche,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] recipe
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEAT   = 3'd1,
        ST_WATER  = 3'd2,
        ST_COFFEE = 3'd3,
        ST_MILK   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] HEAT_LAST   = CNT_W'(T_HEAT - 1);
    localparam logic [CNT_W-1:0] WATER_LAST  = CNT_W'(T_WATER - 1);
    localparam logic [CNT_W-1:0] COFFEE_LAST = CNT_W'(T_COFFEE - 1);
    localparam logic [CNT_W-1:0] MILK_LAST   = CNT_W'(T_MILK - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic [1:0]       recipe_r, recipe_s;

    // State, phase counter and recipe latch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            recipe_r <= 2'b00;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            recipe_r <= recipe_s;
        end
    end

    // Next-state logic; cancel overrides every transition, recipe survives it.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        recipe_s  = recipe_r;
        cnt_inc_s = cnt_r + CNT_ONE;
        if (cancel) begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        case ({m1, m0})
                            2'b01, 2'b11: begin
                                recipe_s = {m1, m0};
                                cnt_s    = CNT_ZERO;
                                state_s  = ST_HEAT;
                            end
                            2'b10:   state_s = ST_ERR;
                            default: state_s = ST_IDLE;
                        endcase
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_HEAT: begin
                    if (cnt_r == HEAT_LAST) begin
                        state_s = ST_WATER;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_WATER: begin
                    if (cnt_r == WATER_LAST) begin
                        state_s = ST_COFFEE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_COFFEE: begin
                    if (cnt_r == COFFEE_LAST) begin
                        state_s = (recipe_r == 2'b11) ? ST_MILK : ST_DONE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_MILK: begin
                    if (cnt_r == MILK_LAST) begin
                        state_s = ST_DONE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Moore decode straight off the state register keeps actuators one-hot.
    assign heater      = (state_r == ST_HEAT);
    assign valve_agua  = (state_r == ST_WATER);
    assign motor_cafe  = (state_r == ST_COFFEE);
    assign valve_leche = (state_r == ST_MILK);
    assign busy        = heater | valve_agua | motor_cafe | valve_leche;
    assign done        = (state_r == ST_DONE);
    assign err         = (state_r == ST_ERR);
    assign recipe      = recipe_r;

endmodule

// File: tb/tb_brew_sequencer.sv
// Scoreboard bench for brew_sequencer: a phase-schedule model queues expected
// outputs, a monitor compares them against the DUT every cycle.
module tb_brew_sequencer;

    localparam int T_HEAT   = 8;
    localparam int T_WATER  = 6;
    localparam int T_COFFEE = 4;
    localparam int T_MILK   = 3;

    // output word: {heater, valve_agua, motor_cafe, valve_leche, busy, done, err}
    localparam logic [6:0] W_IDLE   = 7'b0000000;
    localparam logic [6:0] W_HEAT   = 7'b1000100;
    localparam logic [6:0] W_WATER  = 7'b0100100;
    localparam logic [6:0] W_COFFEE = 7'b0010100;
    localparam logic [6:0] W_MILK   = 7'b0001100;
    localparam logic [6:0] W_DONE   = 7'b0000010;
    localparam logic [6:0] W_ERR    = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset, m1, m0, start, cancel;
    logic       heater, valve_agua, motor_cafe, valve_leche, busy, done, err;
    logic [1:0] recipe;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] sched[$];
    logic [8:0] exp_q[$];
    logic [6:0] cur_word = W_IDLE;
    logic [1:0] m_recipe = 2'b00;

    brew_sequencer #(
        .T_HEAT(T_HEAT), .T_WATER(T_WATER), .T_COFFEE(T_COFFEE), .T_MILK(T_MILK), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .m1(m1), .m0(m0), .start(start), .cancel(cancel),
        .heater(heater), .valve_agua(valve_agua), .motor_cafe(motor_cafe),
        .valve_leche(valve_leche), .busy(busy), .done(done), .err(err), .recipe(recipe)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs, advance the schedule model, queue the expectation.
    task automatic step(input logic r, input logic s, input logic c, input logic [1:0] code);
        logic [6:0] nxt;
        reset  = r;
        start  = s;
        cancel = c;
        {m1, m0} = code;
        if (r) begin
            sched.delete();
            m_recipe = 2'b00;
            nxt = W_IDLE;
        end else if (c) begin
            sched.delete();
            nxt = W_IDLE;
        end else begin
            if (cur_word == W_IDLE && s) begin
                if (code == 2'b01 || code == 2'b11) begin
                    m_recipe = code;
                    repeat (T_HEAT)   sched.push_back(W_HEAT);
                    repeat (T_WATER)  sched.push_back(W_WATER);
                    repeat (T_COFFEE) sched.push_back(W_COFFEE);
                    if (code == 2'b11) begin
                        repeat (T_MILK) sched.push_back(W_MILK);
                    end
                    sched.push_back(W_DONE);
                end else if (code == 2'b10) begin
                    sched.push_back(W_ERR);
                end
            end
            nxt = (sched.size() > 0) ? sched.pop_front() : W_IDLE;
        end
        exp_q.push_back({m_recipe, nxt});
        cur_word = nxt;
        if (r) begin
            #1;
            n_checks++;
            if ({recipe, heater, valve_agua, motor_cafe, valve_leche, busy, done, err} !== 9'd0) begin
                n_fail++;
                $display("FAIL async_reset_outputs got %b expected %b",
                         {recipe, heater, valve_agua, motor_cafe, valve_leche, busy, done, err}, 9'd0);
            end
        end
        @(negedge clk);
        #1;
    endtask

    // Monitor: outputs settle after each posedge; compare at the falling edge.
    initial begin
        logic [8:0] e;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {recipe, heater, valve_agua, motor_cafe, valve_leche, busy, done, err};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got {recipe,h,a,c,l,busy,done,err}=%b expected %b",
                             $time, act, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout, simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; m1 = 1'b0; m0 = 1'b0;
        @(negedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 2'b00);
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'b00);

        // coffee without milk
        step(1'b0, 1'b1, 1'b0, 2'b01);
        repeat (22) step(1'b0, 1'b0, 1'b0, 2'b01);
        // coffee with milk
        step(1'b0, 1'b1, 1'b0, 2'b11);
        repeat (25) step(1'b0, 1'b0, 1'b0, 2'b11);
        // milk unavailable
        step(1'b0, 1'b1, 1'b0, 2'b10);
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'b10);
        // nothing available, start held
        repeat (5) step(1'b0, 1'b1, 1'b0, 2'b00);
        repeat (2) step(1'b0, 1'b0, 1'b0, 2'b00);
        // code switch and start re-pulse mid-brew are ignored
        step(1'b0, 1'b1, 1'b0, 2'b01);
        repeat (9) step(1'b0, 1'b0, 1'b0, 2'b01);
        repeat (5) step(1'b0, 1'b0, 1'b0, 2'b11);
        repeat (2) step(1'b0, 1'b1, 1'b0, 2'b11);
        repeat (10) step(1'b0, 1'b0, 1'b0, 2'b00);
        // cancel during WATER, then a fresh 01 brew
        step(1'b0, 1'b1, 1'b0, 2'b11);
        repeat (9) step(1'b0, 1'b0, 1'b0, 2'b11);
        step(1'b0, 1'b0, 1'b1, 2'b11);
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'b11);
        step(1'b0, 1'b1, 1'b1, 2'b01);
        step(1'b0, 1'b1, 1'b0, 2'b01);
        repeat (22) step(1'b0, 1'b0, 1'b0, 2'b01);
        // start held high re-triggers
        repeat (45) step(1'b0, 1'b1, 1'b0, 2'b01);
        // async reset mid-HEAT
        step(1'b0, 1'b1, 1'b0, 2'b11);
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'b11);
        repeat (2) step(1'b1, 1'b1, 1'b0, 2'b11);
        repeat (3) step(1'b0, 1'b0, 1'b0, 2'b11);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)));
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 2'b00);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
